// File: rtl/uart_pkg.sv
// Shared types and oversampling constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(15);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line plus falling-edge detect.
// All flops reset to 1 so an idle line never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic arst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_rx_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s    = r_sync;
    assign o_rx_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, 1 start + 1 stop bit.
// Optional parity bit when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 i_active,
    input  logic                 i_rx_clk_en,
    input  logic                 i_rx,
    input  logic                 i_parity_odd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic w_rx_s;
    logic w_rx_fall;

    uart_rx_sync u_sync (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_rx      (i_rx),
        .o_rx_s    (w_rx_s),
        .o_rx_fall (w_rx_fall)
    );

    uart_rx_state_e        r_state, w_state_d;
    logic [TICK_W-1:0]     r_tick, w_tick_d;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_d;
    logic [DATA_BITS-1:0]  r_shreg, w_shreg_d;
    logic [DATA_BITS-1:0]  r_rx_data, w_rx_data_d;
    logic                  r_valid, w_valid_d;
    logic                  r_fe, w_fe_d;
    logic                  r_pe, w_pe_d;
    logic                  w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, w_par_bad_d;
    assign w_par_bad = r_par_bad;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = i_parity_odd;
    assign w_par_bad           = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_rx_data <= '0;
            r_valid   <= 1'b0;
            r_fe      <= 1'b0;
            r_pe      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_tick    <= w_tick_d;
            r_bit_cnt <= w_bit_d;
            r_shreg   <= w_shreg_d;
            r_rx_data <= w_rx_data_d;
            r_valid   <= w_valid_d;
            r_fe      <= w_fe_d;
            r_pe      <= w_pe_d;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_d;
`endif
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_tick_d    = r_tick;
        w_bit_d     = r_bit_cnt;
        w_shreg_d   = r_shreg;
        w_rx_data_d = r_rx_data;
        w_valid_d   = 1'b0;
        w_fe_d      = 1'b0;
        w_pe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_d = r_par_bad;
`endif
        if (!i_active) begin
            w_state_d = IDLE;
            w_tick_d  = '0;
            w_bit_d   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rx_fall) begin
                        w_state_d = START;
                        w_tick_d  = '0;
                    end
                end
                START: begin
                    if (i_rx_clk_en) begin
                        if (r_tick == MID_TICK) begin
                            // Line back high at mid-start: glitch, drop silently.
                            w_state_d = w_rx_s ? IDLE : DATA;
                            w_tick_d  = '0;
                            w_bit_d   = '0;
                        end else begin
                            w_tick_d = r_tick + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_rx_clk_en) begin
                        w_tick_d = r_tick + 1'b1;
                        if (r_tick == LAST_TICK) begin
                            w_shreg_d = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                            w_bit_d   = r_bit_cnt + 1'b1;
                            if (r_bit_cnt == LAST_BIT) begin
                                w_bit_d = '0;
`ifdef UART_RX_PARITY_EN
                                w_state_d = PARITY;
`else
                                w_state_d = STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_rx_clk_en) begin
                        w_tick_d = r_tick + 1'b1;
                        if (r_tick == LAST_TICK) begin
                            w_par_bad_d = w_rx_s != ((^r_shreg) ^ i_parity_odd);
                            w_state_d   = STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_rx_clk_en) begin
                        w_tick_d = r_tick + 1'b1;
                        if (r_tick == LAST_TICK) begin
                            w_state_d = IDLE;
                            w_tick_d  = '0;
                            if (!w_rx_s) begin
                                w_rx_data_d = r_shreg;
                                w_fe_d      = 1'b1;
                                w_pe_d      = w_par_bad;
                            end else if (w_par_bad) begin
                                w_pe_d = 1'b1;
                            end else begin
                                w_rx_data_d = r_shreg;
                                w_valid_d   = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_tick_d  = '0;
                    w_bit_d   = '0;
                end
            endcase
        end
    end

    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_valid;
    assign o_frame_err  = r_fe;
    assign o_parity_err = r_pe;
    assign o_busy       = (r_state != IDLE);

endmodule
